// File: rtl/ntt_result_reader_pkg.sv
// Shared definitions for the NTT result read-out path.
// Holds the default bank address width, the coefficient width, the read-out
// FSM state encoding and the bank-index encoding shared with the address
// generator (bank = set*2 + coefficient parity).
package ntt_result_reader_pkg;

  localparam int Addrwidth = 3;
  localparam int DataWidth = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Bank number for a coefficient: the set picks the ram pair, the
  // coefficient parity picks the bank inside the pair.
  function automatic logic [1:0] bank_index(input logic set, input logic parity);
    return {set, parity};
  endfunction

endpackage

// File: rtl/ntt_result_reader_if.sv
// Output stream of the result reader.
// Ports: out_data (coefficient), out_valid, out_last (coefficient N-1),
// out_ready (consumer back-pressure). master = reader, slave = consumer.
interface ntt_result_reader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ntt_skid_fifo2.sv
// Two-entry FIFO with occupancy count; push and pop may happen together.
// Ports: clk, reset (sync, active high), push/push_data, pop, head (oldest
// entry, register-backed), count (0..2). The caller never pushes when full
// and never pops when empty.
module ntt_skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/ntt_result_reader.sv
// Drains a finished NTT/INTT result from the coefficient banks (port B) in
// coefficient order (or bit-reversed order when BITREV=1) and streams it out.
// Ports: clk, reset (sync, active high), start/ram_flag (request + result
// set), ram0..3_enb / r_addr / ram0..3_doutb (bank port B, 1-cycle read),
// out_if (valid/ready stream with last), busy, done (1-cycle pulse).
module ntt_result_reader
  import ntt_result_reader_pkg::*;
#(
  parameter int ADDR_W = Addrwidth,
  parameter int DATA_W = DataWidth,
  parameter int BITREV = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ram_flag,
  output logic              ram0_enb,
  output logic              ram1_enb,
  output logic              ram2_enb,
  output logic              ram3_enb,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] ram0_doutb,
  input  logic [DATA_W-1:0] ram1_doutb,
  input  logic [DATA_W-1:0] ram2_doutb,
  input  logic [DATA_W-1:0] ram3_doutb,
  ntt_result_reader_if.master out_if,
  output logic              busy,
  output logic              done
);

  localparam int KW = ADDR_W + 1;
  localparam logic [KW-1:0] KLast = {KW{1'b1}};

  rd_state_e     state_r, state_s;
  logic          set_r;
  logic [KW-1:0] k_r;
  logic [KW-1:0] rev_s;
  logic [KW-1:0] idx_s;
  logic [1:0]    bank_s;
  logic          inflight_r;
  logic [1:0]    bank_sel_r;
  logic          last_tag_r;
  logic          busy_r;
  logic          done_r;
  logic          issue_s;
  logic          pop_s;
  logic          drain_done_s;
  logic [1:0]    count_s;
  logic [1:0]    credit_s;
  logic [3:0]    enb_s;
  logic [DATA_W:0] push_data_s;
  logic [DATA_W:0] head_s;

  ntt_skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_r),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Coefficient index to read and the bank that holds it.
  always_comb begin
    rev_s = '0;
    for (int i = 0; i < KW; i++) begin
      rev_s[i] = k_r[KW-1-i];
    end
    if (BITREV != 0) begin
      idx_s = rev_s;
    end else begin
      idx_s = k_r;
    end
    bank_s = bank_index(set_r, idx_s[0]);
  end

  // Read issue: an entry popped this cycle frees its slot immediately, which
  // is what sustains one coefficient per cycle with out_ready held high.
  always_comb begin
    pop_s    = (count_s != 2'd0) && out_if.out_ready;
    credit_s = count_s - {1'b0, pop_s} + {1'b0, inflight_r};
    issue_s  = (state_r == ST_READ) && (credit_s < 2'd2);
    enb_s    = 4'b0000;
    r_addr   = '0;
    if (issue_s) begin
      enb_s[bank_s] = 1'b1;
      r_addr        = idx_s[KW-1:1];
    end else begin
      enb_s  = 4'b0000;
      r_addr = '0;
    end
  end

  assign ram0_enb = enb_s[0];
  assign ram1_enb = enb_s[1];
  assign ram2_enb = enb_s[2];
  assign ram3_enb = enb_s[3];

  // Select the returning bank's data and attach the last tag.
  always_comb begin
    push_data_s = '0;
    case (bank_sel_r)
      2'd0:    push_data_s = {last_tag_r, ram0_doutb};
      2'd1:    push_data_s = {last_tag_r, ram1_doutb};
      2'd2:    push_data_s = {last_tag_r, ram2_doutb};
      2'd3:    push_data_s = {last_tag_r, ram3_doutb};
      default: push_data_s = '0;
    endcase
  end

  // Next-state logic; DRAIN ends on the handshake of the tagged last entry,
  // which is necessarily the only entry left with nothing in flight.
  always_comb begin
    state_s      = state_r;
    drain_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_s && (k_r == KLast)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_s[DATA_W] && (count_s == 2'd1) && !inflight_r) begin
          drain_done_s = 1'b1;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters, in-flight tracking and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      set_r      <= 1'b0;
      k_r        <= '0;
      inflight_r <= 1'b0;
      bank_sel_r <= 2'd0;
      last_tag_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= issue_s;
      done_r     <= drain_done_s;
      if ((state_r == ST_IDLE) && start) begin
        set_r  <= ram_flag;
        k_r    <= '0;
        busy_r <= 1'b1;
      end
      if (issue_s) begin
        bank_sel_r <= bank_s;
        last_tag_r <= (k_r == KLast);
        k_r        <= k_r + {{(KW-1){1'b0}}, 1'b1};
      end
      if (drain_done_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = (count_s != 2'd0);
  assign out_if.out_data  = head_s[DATA_W-1:0];
  assign out_if.out_last  = head_s[DATA_W];
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_ntt_result_reader.sv
// Scoreboard bench: dut0 (ADDR_W=3, N=16, natural order) and dut1
// (ADDR_W=2, N=8, bit-reversed order). Bank contents are defined so that
// coefficient c of set s reads as s*0x100 + c.
module tb_ntt_result_reader;

  localparam int N0 = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // dut0 signals
  logic        start0, flag0;
  logic        e00, e01, e02, e03;
  logic [2:0]  addr0;
  logic [15:0] d00, d01, d02, d03;
  logic        busy0, done0;
  ntt_result_reader_if #(.DATA_W(16)) if0 ();

  // dut1 signals
  logic        start1, flag1;
  logic        e10, e11, e12, e13;
  logic [1:0]  addr1;
  logic [15:0] d10, d11, d12, d13;
  logic        busy1, done1;
  ntt_result_reader_if #(.DATA_W(16)) if1 ();

  ntt_result_reader #(.ADDR_W(3), .DATA_W(16), .BITREV(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .ram_flag(flag0),
    .ram0_enb(e00), .ram1_enb(e01), .ram2_enb(e02), .ram3_enb(e03),
    .r_addr(addr0),
    .ram0_doutb(d00), .ram1_doutb(d01), .ram2_doutb(d02), .ram3_doutb(d03),
    .out_if(if0), .busy(busy0), .done(done0)
  );

  ntt_result_reader #(.ADDR_W(2), .DATA_W(16), .BITREV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ram_flag(flag1),
    .ram0_enb(e10), .ram1_enb(e11), .ram2_enb(e12), .ram3_enb(e13),
    .r_addr(addr1),
    .ram0_doutb(d10), .ram1_doutb(d11), .ram2_doutb(d12), .ram3_doutb(d13),
    .out_if(if1), .busy(busy1), .done(done1)
  );

  function automatic logic [15:0] ram_val(input int bank, input int addr);
    return 16'((bank / 2) * 256 + 2 * addr + (bank % 2));
  endfunction

  // Bank port-B models: one-cycle registered read.
  always @(posedge clk) begin
    if (e00) d00 <= ram_val(0, int'(addr0));
    if (e01) d01 <= ram_val(1, int'(addr0));
    if (e02) d02 <= ram_val(2, int'(addr0));
    if (e03) d03 <= ram_val(3, int'(addr0));
    if (e10) d10 <= ram_val(0, int'(addr1));
    if (e11) d11 <= ram_val(1, int'(addr1));
    if (e12) d12 <= ram_val(2, int'(addr1));
    if (e13) d13 <= ram_val(3, int'(addr1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [16:0] exp_q[$];
  logic [15:0] exp1 [8];
  int          idx1 = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          done1_cnt = 0, done1_cyc = 0;
  int          fv_cyc = 0;
  bit          fv_seen = 1'b0;
  bit          stall0 = 1'b0;
  logic [15:0] held0 = 16'h0000;
  int          enb_viol = 0;
  bit          forbid_hi = 1'b1;
  int          ready_mode = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) if0.out_ready = 1'b1;
      else if0.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  // Monitor: compares every handshake against the scoreboard queue.
  initial begin
    logic [16:0] e;
    logic [3:0]  en;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall0 = 1'b0;
      end else begin
        if (stall0) chk("stall_hold", {15'd0, if0.out_valid, if0.out_data}, {15'd0, 1'b1, held0});
        if (if0.out_valid && !fv_seen) begin
          fv_seen = 1'b1;
          fv_cyc  = cyc;
        end
        if (if0.out_valid && if0.out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h expected nothing", if0.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {15'd0, if0.out_last, if0.out_data}, {15'd0, e});
          end
        end
        stall0 = if0.out_valid && !if0.out_ready;
        held0  = if0.out_data;
        en = {e03, e02, e01, e00};
        if (($countones(en) > 1) || (forbid_hi ? |en[3:2] : |en[1:0])) enb_viol++;
        if (done0) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (if1.out_valid && if1.out_ready) begin
          if (idx1 < 8) begin
            chk("bitrev_word", {15'd0, if1.out_last, if1.out_data},
                {15'd0, (idx1 == 7), exp1[idx1]});
          end else begin
            checks++;
            errors++;
            $display("FAIL bitrev_extra: got 0x%0h expected nothing", if1.out_data);
          end
          idx1++;
        end
        if (done1) begin
          done1_cnt++;
          done1_cyc = cyc;
        end
      end
    end
  end

  task automatic chk_zero(input string name);
    chk(name, {if0.out_valid, if0.out_last, if0.out_data, busy0, done0,
               e03, e02, e01, e00, addr0}, 32'd0);
  endtask

  // Pulses start on dut0; returns the cycle number of the sampling edge.
  task automatic pulse_start0(input logic flag, output int s_cyc);
    @(posedge clk);
    #1;
    start0 = 1'b1;
    flag0  = flag;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    flag0  = ~flag;
    s_cyc  = cyc;
  endtask

  task automatic run0(input logic flag, input int mode, input bit check_lat);
    int s_cyc;
    int base_done;
    ready_mode = mode;
    forbid_hi  = ~flag;
    enb_viol   = 0;
    fv_seen    = 1'b0;
    base_done  = done_cnt;
    for (int c = 0; c < N0; c++) begin
      exp_q.push_back({(c == N0 - 1), 16'((flag ? 256 : 0) + c)});
    end
    pulse_start0(flag, s_cyc);
    chk("busy_after_start", {31'd0, busy0}, 32'd1);
    for (int i = 0; i < 400 && done_cnt == base_done; i++) @(posedge clk);
    #1;
    chk("done_count", done_cnt - base_done, 32'd1);
    if (check_lat) begin
      chk("first_valid_latency", fv_cyc - s_cyc, 32'd2);
      chk("done_latency", done_cyc - s_cyc, 32'(N0 + 2));
    end
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("enb_set_select", enb_viol, 32'd0);
    chk("busy_after_done", {31'd0, busy0}, 32'd0);
    ready_mode = 0;
  endtask

  task automatic run_reset();
    int s_cyc;
    int base_hs;
    int base_done;
    ready_mode = 0;
    forbid_hi  = 1'b1;
    enb_viol   = 0;
    base_hs    = hs_cnt;
    base_done  = done_cnt;
    for (int c = 0; c < N0; c++) exp_q.push_back({(c == N0 - 1), 16'(c)});
    pulse_start0(1'b0, s_cyc);
    repeat (2) @(posedge clk);
    #1;
    start0 = 1'b1;
    flag0  = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    flag0  = 1'b0;
    for (int i = 0; i < 200 && (hs_cnt - base_hs) < 5; i++) @(posedge clk);
    #1;
    chk("reached_coef5", hs_cnt - base_hs, 32'd5);
    chk("second_start_ignored", enb_viol, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_zero("outputs_in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero("outputs_after_reset");
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt, base_done);
  endtask

  initial begin
    int s1;
    exp1[0] = 16'd0; exp1[1] = 16'd4; exp1[2] = 16'd2; exp1[3] = 16'd6;
    exp1[4] = 16'd1; exp1[5] = 16'd5; exp1[6] = 16'd3; exp1[7] = 16'd7;
    reset  = 1'b1;
    start0 = 1'b0;
    flag0  = 1'b0;
    start1 = 1'b0;
    flag1  = 1'b0;
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run0(1'b0, 0, 1'b1);
    run0(1'b1, 0, 1'b1);
    run0(1'b0, 1, 1'b0);
    run_reset();
    run0(1'b0, 0, 1'b1);

    @(posedge clk);
    #1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    s1 = cyc;
    for (int i = 0; i < 200 && done1_cnt == 0; i++) @(posedge clk);
    #1;
    chk("bitrev_count", idx1, 32'd8);
    chk("bitrev_done_latency", done1_cyc - s1, 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
